sprite_sdr_port: RTL and testbench

//  Responder side of the sprite-fetch SDRAM port. Accepts single 64-bit read requests from the sprite

---
 rtl/sprite_sdr_port_if.sv | 13 +
 rtl/sprite_sdr_port.sv | 159 +++++++++++++++
 tb/tb_sprite_sdr_port.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_sdr_port_if.sv
// Renderer-side fetch bus of the sprite SDRAM port: one-cycle request strobe with
// address and idle hint in, 64-bit word with completion pulse and overrun flag out.
interface sprite_sdr_port_if;
    logic        req;
    logic [24:0] addr;
    logic        refresh_hint;
    logic [63:0] data;
    logic        rdy;
    logic        overrun;

    modport master (output req, addr, refresh_hint, input data, rdy, overrun);
    modport slave  (input req, addr, refresh_hint, output data, rdy, overrun);
endinterface

// File: rtl/sprite_sdr_port.sv
// Sprite-fetch SDR SDRAM responder: ACT + READ (BL4, auto-precharge) per request, refresh scheduling
// with early refresh on renderer idle. Optional SPRITE_SDR_STATS_EN adds read/refresh counters.
module sprite_sdr_port #(
    parameter int CAS_LAT      = 2,
    parameter int T_RCD        = 2,
    parameter int T_RC         = 6,
    parameter int REF_INTERVAL = 1560
) (
    input  logic        clk,
    input  logic        reset_n,
    sprite_sdr_port_if.slave rb,
    output logic [3:0]  sd_cmd,
    output logic [1:0]  sd_ba,
    output logic [12:0] sd_a,
    output logic [1:0]  sd_dqm,
    input  logic [15:0] sd_dq_in
`ifdef SPRITE_SDR_STATS_EN
    ,
    output logic [15:0] stat_reads,
    output logic [15:0] stat_refs
`endif
);
    localparam int RCW = $clog2(REF_INTERVAL + 1);
    localparam int RCC = $clog2(T_RC + 1);
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_REF  = 4'b0001;

    typedef enum logic [3:0] {
        IDLE, ACT, RCD_WAIT, READ, CAS_WAIT, DATA, DONE, TRC_WAIT, REF, REF_WAIT
    } state_t;

    state_t           state;
    logic [RCW-1:0]   ref_cnt;
    logic [RCC-1:0]   rc_cnt;
    logic [3:0]       wcnt;
    logic             pend_vld;
    logic [24:3]      pend_addr;
    logic [6:0]       cur_col;
    logic [47:0]      shreg;

    logic             ref_due, early, have_req, idle_point, go_ref, go_act;
    logic [24:3]      launch_addr;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^rb.addr[2:0];
    assign ref_due     = (ref_cnt == '0);
    assign early       = (ref_cnt < RCW'(REF_INTERVAL / 2));
    assign have_req    = pend_vld | rb.req;
    // Wait states hand over to the idle decision the cycle tRC expires, so back-to-back work loses no cycle.
    assign idle_point  = (state == IDLE || state == TRC_WAIT || state == REF_WAIT) && (rc_cnt == '0);
    assign go_ref      = idle_point && (ref_due || (!have_req && rb.refresh_hint && early));
    assign go_act      = idle_point && !ref_due && have_req;
    assign launch_addr = pend_vld ? pend_addr : rb.addr[24:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sd_cmd     <= CMD_NOP;
            sd_ba      <= '0;
            sd_a       <= '0;
            sd_dqm     <= 2'b11;
            rb.data    <= '0;
            rb.rdy     <= 1'b0;
            rb.overrun <= 1'b0;
            ref_cnt    <= RCW'(REF_INTERVAL);
            rc_cnt     <= '0;
            wcnt       <= '0;
            pend_vld   <= 1'b0;
`ifdef SPRITE_SDR_STATS_EN
            stat_reads <= '0;
            stat_refs  <= '0;
`endif
        end else begin
            sd_cmd <= CMD_NOP;
            rb.rdy <= 1'b0;
            if (rc_cnt != '0) rc_cnt <= rc_cnt - 1'b1;
            if (go_ref)              ref_cnt <= RCW'(REF_INTERVAL);
            else if (ref_cnt != '0)  ref_cnt <= ref_cnt - 1'b1;

            // A request launched straight from IDLE bypasses the slot; a full slot drops the newcomer.
            if (rb.req) begin
                if (pend_vld)     rb.overrun <= 1'b1;
                else if (!go_act) pend_vld   <= 1'b1;
            end
            if (go_act && pend_vld) pend_vld <= 1'b0;

            if (go_ref) begin
                state  <= REF;
                sd_cmd <= CMD_REF;
                rc_cnt <= RCC'(T_RC - 1);
`ifdef SPRITE_SDR_STATS_EN
                stat_refs <= stat_refs + 16'd1;
`endif
            end else if (go_act) begin
                state  <= ACT;
                sd_cmd <= CMD_ACT;
                sd_ba  <= launch_addr[24:23];
                sd_a   <= launch_addr[22:10];
                rc_cnt <= RCC'(T_RC - 1);
            end else begin
                case (state)
                    IDLE: ;
                    TRC_WAIT, REF_WAIT: if (rc_cnt == '0) state <= IDLE;
                    ACT: begin
                        state <= RCD_WAIT;
                        wcnt  <= 4'(T_RCD - 2);
                    end
                    RCD_WAIT: begin
                        if (wcnt == '0) begin
                            state  <= READ;
                            sd_cmd <= CMD_READ;
                            sd_a   <= {2'b00, 1'b1, 1'b0, cur_col, 2'b00};
                            sd_dqm <= 2'b00;
                        end else begin
                            wcnt <= wcnt - 1'b1;
                        end
                    end
                    READ: begin
                        state <= CAS_WAIT;
                        wcnt  <= 4'(CAS_LAT - 2);
                    end
                    CAS_WAIT: begin
                        if (wcnt == '0) begin
                            state <= DATA;
                            wcnt  <= 4'd3;
                        end else begin
                            wcnt <= wcnt - 1'b1;
                        end
                    end
                    DATA: begin
                        if (wcnt == '0) begin
                            state   <= DONE;
                            rb.data <= {sd_dq_in, shreg};
                            rb.rdy  <= 1'b1;
                            sd_dqm  <= 2'b11;
`ifdef SPRITE_SDR_STATS_EN
                            stat_reads <= stat_reads + 16'd1;
`endif
                        end else begin
                            wcnt <= wcnt - 1'b1;
                        end
                    end
                    DONE:    state <= TRC_WAIT;
                    REF:     state <= REF_WAIT;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Datapath registers: burst assembly, column and parked address need no reset.
    always_ff @(posedge clk) begin
        if (state == DATA) shreg <= {sd_dq_in, shreg[47:16]};
        if (go_act) cur_col <= launch_addr[9:3];
        if (rb.req && !pend_vld && !go_act) pend_addr <= rb.addr[24:3];
    end
endmodule

// File: tb/tb_sprite_sdr_port.sv
// Scoreboard bench for sprite_sdr_port: directed requests push expected bus events,
// a monitor pops and compares each command/rdy the DUT presents; an SDRAM model supplies read bursts.
`timescale 1ns/1ps
module tb_sprite_sdr_port;
    localparam int CAS_LAT = 2;
    localparam int K_ACT = 0, K_READ = 1, K_REF = 2, K_RDY = 3, K_BAD = 9;

    typedef struct {
        int          kind;
        int          cyc;
        logic [1:0]  ba;
        logic [12:0] a;
        logic [63:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  sd_cmd;
    logic [1:0]  sd_ba;
    logic [12:0] sd_a;
    logic [1:0]  sd_dqm;
    logic [15:0] sd_dq_in = 16'hDEAD;
`ifdef SPRITE_SDR_STATS_EN
    logic [15:0] stat_reads, stat_refs;
`endif

    sprite_sdr_port_if rb();

    sprite_sdr_port dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rb       (rb),
        .sd_cmd   (sd_cmd),
        .sd_ba    (sd_ba),
        .sd_a     (sd_a),
        .sd_dqm   (sd_dqm),
        .sd_dq_in (sd_dq_in)
`ifdef SPRITE_SDR_STATS_EN
        ,
        .stat_reads (stat_reads),
        .stat_refs  (stat_refs)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int t0 = 0;
    int n_tests = 0;
    int n_fail = 0;
    ev_t exp_q[$];
    logic [63:0] burst_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc - t0);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input logic [1:0] ba,
                           input logic [12:0] a, input logic [63:0] d);
        ev_t e;
        e.kind = kind; e.cyc = t0 + c; e.ba = ba; e.a = a; e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic int cmd_kind(input logic [3:0] c);
        case (c)
            4'b0011: return K_ACT;
            4'b0101: return K_READ;
            4'b0001: return K_REF;
            default: return K_BAD;
        endcase
    endfunction

    task automatic check_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc - t0);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            chk("event_cycle", 64'(cyc - t0), 64'(e.cyc - t0));
            if (kind == e.kind) begin
                if (kind == K_ACT)  begin chk("act_ba", 64'(sd_ba), 64'(e.ba)); chk("act_row", 64'(sd_a), 64'(e.a)); end
                if (kind == K_READ) chk("read_a", 64'(sd_a), 64'(e.a));
                if (kind == K_RDY)  chk("rdy_data", rb.data, e.data);
            end
        end
    endtask

    // Monitor: every non-NOP command and every rdy pulse must match the head of the queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (sd_cmd != 4'b0111) check_ev(cmd_kind(sd_cmd));
            if (rb.rdy) check_ev(K_RDY);
        end
    end

    // SDRAM read model: four words starting CAS_LAT cycles after each READ.
    int rd_cyc = -100;
    logic [63:0] rd_data = '0;
    always @(negedge clk) begin
        if (reset_n && sd_cmd == 4'b0101) begin
            rd_cyc = cyc;
            rd_data = (burst_q.size() != 0) ? burst_q.pop_front() : 64'h0;
        end
        sd_dq_in = 16'hDEAD;
        for (int i = 0; i < 4; i++)
            if (cyc == rd_cyc + CAS_LAT + i) sd_dq_in = rd_data[16*i +: 16];
    end

    task automatic at(input int n);
        while (cyc - t0 < n) @(negedge clk);
    endtask

    task automatic req_at(input int n, input logic [24:0] a);
        at(n);
        rb.req = 1'b1;
        rb.addr = a;
        @(negedge clk);
        rb.req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd", 64'(sd_cmd), 64'h7);
        chk("rst_dqm", 64'(sd_dqm), 64'h3);
        chk("rst_ba", 64'(sd_ba), 64'h0);
        chk("rst_a", 64'(sd_a), 64'h0);
        chk("rst_data", rb.data, 64'h0);
        chk("rst_rdy", 64'(rb.rdy), 64'h0);
        chk("rst_overrun", 64'(rb.overrun), 64'h0);
        exp_q.delete();
        burst_q.delete();
        reset_n = 1'b1;
        t0 = cyc;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", 64'(exp_q.size()), 64'h0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rb.req = 1'b0;
        rb.addr = '0;
        rb.refresh_hint = 1'b0;

        // Basic fetch: ACT@1, READ@3, words 5..8, rdy@9
        do_reset();
        push_ev(K_ACT, 1, 2'd0, 13'h0284, '0);
        push_ev(K_READ, 3, 2'd0, 13'h051C, '0);
        push_ev(K_RDY, 9, 2'd0, '0, 64'h4444_3333_2222_1111);
        burst_q.push_back(64'h4444_3333_2222_1111);
        req_at(0, 25'h0A_1238);
        at(2);  chk("dqm_before_read", 64'(sd_dqm), 64'h3);
        at(5);  chk("dqm_in_data", 64'(sd_dqm), 64'h0);
        at(10); chk("dqm_after_done", 64'(sd_dqm), 64'h3);
        drain(40);

        // Forced refresh at 1561, then a request one cycle later waits out tRC
        do_reset();
        push_ev(K_REF, 1561, '0, '0, '0);
        push_ev(K_ACT, 1567, 2'd3, 13'h1FFF, '0);
        push_ev(K_READ, 1569, 2'd0, 13'h05FC, '0);
        push_ev(K_RDY, 1575, 2'd0, '0, 64'hDDDD_CCCC_BBBB_AAAA);
        burst_q.push_back(64'hDDDD_CCCC_BBBB_AAAA);
        req_at(1562, 25'h1FF_FFF8);
        drain(40);

        // Early refresh: hint from 800 (counter already below half)
        do_reset();
        push_ev(K_REF, 801, '0, '0, '0);
        at(800); rb.refresh_hint = 1'b1;
        at(806); rb.refresh_hint = 1'b0;
        drain(20);

        // Early refresh boundary: counter 780 at cycle 780 does not qualify, 779 at 781 does
        do_reset();
        push_ev(K_REF, 782, '0, '0, '0);
        at(700); rb.refresh_hint = 1'b1;
        at(790); rb.refresh_hint = 1'b0;
        drain(20);

        // Three requests: two served in order, third dropped, overrun sticky
        do_reset();
        push_ev(K_ACT, 1, 2'd0, 13'h0000, '0);
        push_ev(K_READ, 3, 2'd0, 13'h0420, '0);
        push_ev(K_RDY, 9, 2'd0, '0, 64'h0004_0003_0002_0001);
        push_ev(K_ACT, 11, 2'd2, 13'h0155, '0);
        push_ev(K_READ, 13, 2'd0, 13'h04C4, '0);
        push_ev(K_RDY, 19, 2'd0, '0, 64'h5678_1234_BEEF_F00D);
        burst_q.push_back(64'h0004_0003_0002_0001);
        burst_q.push_back(64'h5678_1234_BEEF_F00D);
        req_at(0, 25'h000_0040);
        req_at(2, 25'h105_5588);
        at(3); chk("overrun_before_drop", 64'(rb.overrun), 64'h0);
        req_at(4, 25'h0AB_CDE8);
        chk("overrun_after_drop", 64'(rb.overrun), 64'h1);
        drain(60);
        chk("overrun_sticky", 64'(rb.overrun), 64'h1);

        // Reset during DATA aborts with no rdy; next request completes cleanly
        do_reset();
        push_ev(K_ACT, 1, 2'd0, 13'h0000, '0);
        push_ev(K_READ, 3, 2'd0, 13'h0420, '0);
        burst_q.push_back(64'h9999_8888_7777_6666);
        req_at(0, 25'h000_0040);
        at(6);
        reset_n = 1'b0;
        #1;
        chk("abort_cmd", 64'(sd_cmd), 64'h7);
        chk("abort_dqm", 64'(sd_dqm), 64'h3);
        chk("abort_rdy", 64'(rb.rdy), 64'h0);
        chk("abort_pending", 64'(exp_q.size()), 64'h0);
        repeat (3) @(negedge clk);
        burst_q.delete();
        reset_n = 1'b1;
        t0 = cyc;
        push_ev(K_ACT, 1, 2'd2, 13'h0155, '0);
        push_ev(K_READ, 3, 2'd0, 13'h04C4, '0);
        push_ev(K_RDY, 9, 2'd0, '0, 64'hCAFE_0123_4567_89AB);
        burst_q.push_back(64'hCAFE_0123_4567_89AB);
        req_at(0, 25'h105_5588);
        drain(40);
        chk("final_overrun", 64'(rb.overrun), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
